// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared pipeline definitions for the hazard/sequencing control
//               of the 5-stage core: controller states, register constants
//               and the default mul/div watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Controller states: normal issue, or holding while the mul/div unit runs
    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Architectural zero register; a load targeting it never creates a hazard
    localparam logic [4:0] c_REG_X0 = 5'd0;

    // Default watchdog limit on mul/div wait cycles
    localparam int c_MD_MAX_CYCLES_DEFAULT = 34;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with increment enable and synchronous
//               clear. Holds at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    // Count up on enable, stick at the maximum value, clear has priority
    always_ff @(posedge clk) begin
        if (i_clr) begin
            o_count <= '0;
        end else if (i_inc && (o_count != {W{1'b1}})) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline sequencing controller. Stalls on load-use hazards,
//               flushes on EX redirects, sequences the multi-cycle mul/div
//               unit with a start/done handshake and a watchdog, and keeps
//               saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYCLES = c_MD_MAX_CYCLES_DEFAULT,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [4:0]       EX_rd,
    input  logic             EX_MemRead,
    input  logic             EX_md_op,
    input  logic             EX_redirect,
    input  logic             md_done,
    output logic             md_start,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_bubble,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int c_WAIT_W = $clog2(MD_MAX_CYCLES + 1);

    state_t              r_state;
    state_t              w_state_next;
    state_t              w_state_eff;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_lu;
    logic                w_timeout;
    logic                w_release;

    // Hazard detection and mul/div wait termination
    always_comb begin
        w_lu = EX_MemRead && (EX_rd != c_REG_X0) &&
               ((ID_use_rs1 && (ID_rs1 == EX_rd)) ||
                (ID_use_rs2 && (ID_rs2 == EX_rd)));
        // While reset is held the outputs behave as in RUN whatever the state
        w_state_eff = rstn ? r_state : RUN;
        w_timeout   = (r_state == MD_WAIT) && !md_done &&
                      (r_wait_cnt == c_WAIT_W'(MD_MAX_CYCLES));
        w_release   = (r_state == MD_WAIT) && (md_done || w_timeout);
    end

    // State register, wait counter and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            md_error   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Held at zero in RUN so it starts clean on entering MD_WAIT
            if (r_state == RUN) begin
                r_wait_cnt <= '0;
            end else if (!w_release) begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end
            if (w_timeout) begin
                md_error <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (EX_md_op)  w_state_next = MD_WAIT;
            MD_WAIT: if (w_release) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // Pipeline control outputs, prioritised mul/div > redirect > load-use
    always_comb begin
        md_start      = 1'b0;
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        ID_EX_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_flush   = 1'b0;
        EX_MEM_bubble = 1'b0;
        case (w_state_eff)
            RUN: begin
                if (EX_md_op) begin
                    md_start      = rstn;
                    PC_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    ID_EX_write   = 1'b0;
                    EX_MEM_bubble = 1'b1;
                end else if (EX_redirect) begin
                    // The ID instruction is squashed, so load-use is moot
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (w_lu) begin
                    PC_write    = 1'b0;
                    IF_ID_write = 1'b0;
                    ID_EX_flush = 1'b1;
                end
            end
            MD_WAIT: begin
                // Freeze until done or watchdog; on release EX advances
                if (!w_release) begin
                    PC_write      = 1'b0;
                    IF_ID_write   = 1'b0;
                    ID_EX_write   = 1'b0;
                    EX_MEM_bubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clr   (!rstn),
        .i_inc   (!PC_write),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .i_clr   (!rstn),
        .i_inc   (IF_ID_flush),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MD_MAX = 8;
    localparam int CW     = 32;

    // Control vector order: md_start, PC_write, IF_ID_write, ID_EX_write,
    //                       IF_ID_flush, ID_EX_flush, EX_MEM_bubble
    localparam logic [6:0] c_NORMAL = 7'b0111000;
    localparam logic [6:0] c_ISSUE  = 7'b1000001;
    localparam logic [6:0] c_FREEZE = 7'b0000001;
    localparam logic [6:0] c_REDIR  = 7'b0111110;
    localparam logic [6:0] c_LU     = 7'b0001010;

    logic          clk = 1'b0;
    logic          rstn;
    logic [4:0]    ID_rs1, ID_rs2, EX_rd;
    logic          ID_use_rs1, ID_use_rs2, EX_MemRead, EX_md_op, EX_redirect, md_done;
    logic          md_start, PC_write, IF_ID_write, ID_EX_write;
    logic          IF_ID_flush, ID_EX_flush, EX_MEM_bubble, md_error;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    w_ctrl;

    int checks   = 0;
    int failures = 0;
    int n_start;
    int n_bubble;

    hazard_ctrl #(
        .MD_MAX_CYCLES (MD_MAX),
        .CNT_W         (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ID_rs1        (ID_rs1),
        .ID_rs2        (ID_rs2),
        .ID_use_rs1    (ID_use_rs1),
        .ID_use_rs2    (ID_use_rs2),
        .EX_rd         (EX_rd),
        .EX_MemRead    (EX_MemRead),
        .EX_md_op      (EX_md_op),
        .EX_redirect   (EX_redirect),
        .md_done       (md_done),
        .md_start      (md_start),
        .PC_write      (PC_write),
        .IF_ID_write   (IF_ID_write),
        .ID_EX_write   (ID_EX_write),
        .IF_ID_flush   (IF_ID_flush),
        .ID_EX_flush   (ID_EX_flush),
        .EX_MEM_bubble (EX_MEM_bubble),
        .md_error      (md_error),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    assign w_ctrl = {md_start, PC_write, IF_ID_write, ID_EX_write,
                     IF_ID_flush, ID_EX_flush, EX_MEM_bubble};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
        ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0;
        EX_MemRead = 1'b0; EX_md_op = 1'b0; EX_redirect = 1'b0; md_done = 1'b0;
    endtask

    initial begin
        idle();
        rstn     = 1'b0;
        EX_md_op = 1'b1;
        #1;
        check("reset_ctrl_md_op", 64'(w_ctrl), 64'(c_FREEZE));
        tick();
        tick();
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset_flush_cnt", 64'(flush_cnt), 64'd0);
        check("reset_md_error", 64'(md_error), 64'd0);

        rstn = 1'b1;
        idle();
        #1;
        check("idle_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        tick();

        // Load-use on rs1: one stall cycle
        EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        #1;
        check("lu_rs1_ctrl", 64'(w_ctrl), 64'(c_LU));
        tick();
        EX_MemRead = 1'b0;
        #1;
        check("lu_next_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // Load to x0 never stalls
        idle();
        EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs2 = 5'd0; ID_use_rs2 = 1'b1;
        #1;
        check("x0_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        tick();

        // Matching but unused source never stalls
        idle();
        EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_use_rs1 = 1'b0;
        #1;
        check("unused_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        tick();

        // Load-use on rs2
        idle();
        EX_MemRead = 1'b1; EX_rd = 5'd9; ID_rs2 = 5'd9; ID_use_rs2 = 1'b1;
        #1;
        check("lu_rs2_ctrl", 64'(w_ctrl), 64'(c_LU));
        tick();
        check("lu_rs2_stall_cnt", 64'(stall_cnt), 64'd2);

        // Redirect overrides load-use
        idle();
        EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
        EX_redirect = 1'b1;
        #1;
        check("redir_ctrl", 64'(w_ctrl), 64'(c_REDIR));
        tick();
        idle();
        #1;
        check("redir_flush_cnt", 64'(flush_cnt), 64'd1);
        check("redir_stall_cnt", 64'(stall_cnt), 64'd2);

        // md_done in RUN is ignored
        md_done = 1'b1;
        #1;
        check("done_in_run_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        tick();
        md_done = 1'b0;
        #1;
        check("done_in_run_after", 64'(w_ctrl), 64'(c_NORMAL));
        tick();

        // Divider with latency 5
        n_start  = 0;
        n_bubble = 0;
        EX_md_op = 1'b1;
        #1;
        check("md_issue_ctrl", 64'(w_ctrl), 64'(c_ISSUE));
        n_start  += int'(md_start);
        n_bubble += int'(EX_MEM_bubble);
        tick();
        for (int k = 1; k <= 5; k++) begin
            md_done = (k == 5);
            #1;
            if (k < 5) check($sformatf("md_wait%0d_ctrl", k), 64'(w_ctrl), 64'(c_FREEZE));
            else       check("md_done_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
            n_start  += int'(md_start);
            n_bubble += int'(EX_MEM_bubble);
            tick();
        end
        idle();
        #1;
        check("md_start_pulses", 64'(n_start), 64'd1);
        check("md_bubble_cycles", 64'(n_bubble), 64'd5);
        check("md_after_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        check("md_stall_cnt", 64'(stall_cnt), 64'd7);
        tick();

        // Watchdog: no done ever
        EX_md_op = 1'b1;
        #1;
        check("wd_issue_ctrl", 64'(w_ctrl), 64'(c_ISSUE));
        tick();
        for (int k = 1; k <= MD_MAX; k++) begin
            #1;
            check($sformatf("wd_wait%0d_ctrl", k), 64'(w_ctrl), 64'(c_FREEZE));
            tick();
        end
        #1;
        check("wd_release_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        check("wd_error_before", 64'(md_error), 64'd0);
        tick();
        EX_md_op = 1'b0;
        #1;
        check("wd_error_set", 64'(md_error), 64'd1);
        check("wd_after_ctrl", 64'(w_ctrl), 64'(c_NORMAL));
        check("wd_stall_cnt", 64'(stall_cnt), 64'd16);
        tick();
        tick();
        check("wd_error_sticky", 64'(md_error), 64'd1);

        // Reset while waiting on the divider
        EX_md_op = 1'b1;
        tick();
        #1;
        check("rst_mid_wait_ctrl", 64'(w_ctrl), 64'(c_FREEZE));
        tick();
        rstn = 1'b0;
        #1;
        check("rst_mid_md_start", 64'(w_ctrl), 64'(c_FREEZE));
        tick();
        rstn     = 1'b1;
        EX_md_op = 1'b0;
        #1;
        check("rst_mid_state_run", 64'(w_ctrl), 64'(c_NORMAL));
        check("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_mid_flush_cnt", 64'(flush_cnt), 64'd0);
        check("rst_mid_md_error", 64'(md_error), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
